// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus request sequencer that feeds a UART
// transmitter. Bytes go out back-to-back, in write order, with the
// start/active handshake handled here. Single clock (the bit clock),
// synchronous active-low reset.
module uart_tx_feeder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            wrData,
  input  logic                  wrEnable,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic [7:0]            txData,
  output logic                  txRequest,
  input  logic                  txStarted,
  input  logic                  txActive
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    BUSY
  } state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic                  push;
  logic                  pop;

  // Status flags come straight from the registered count.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Pop when the transmitter acknowledges the pending request. A write
  // while full still lands if a pop frees the slot in the same cycle.
  always_comb begin
    pop  = (state == REQUEST) && txStarted;
    push = wrEnable && (!full || pop);
  end

  // Storage array; stale contents after reset are unreachable because
  // the pointers and count restart at zero.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      mem[wrPtr] <= wrData;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
      if (wrEnable && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Request sequencer. txData is latched only on IDLE->REQUEST, so it is
  // stable for the whole time txRequest is high; the head entry is popped
  // only after the transmitter has signalled that it latched it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      txData    <= '0;
      txRequest <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty && !txActive) begin
            txData    <= mem[rdPtr];
            txRequest <= 1'b1;
            state     <= REQUEST;
          end
        end
        REQUEST: begin
          if (txStarted) begin
            txRequest <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (!txActive) begin
            state <= IDLE;
          end
        end
        default: begin
          txRequest <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: behavioural transmitter, serial-line
// monitor with an expected-byte queue, and directed stimulus.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clock    = 1'b0;
  logic          reset    = 1'b0;
  logic [7:0]    wrData   = '0;
  logic          wrEnable = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic [7:0]    txData;
  logic          txRequest;
  logic          txStarted;
  logic          txActive;

  // When stalled, the bench drives the handshake instead of the transmitter.
  logic          stall        = 1'b0;
  logic          fake_started = 1'b0;
  logic          fake_active  = 1'b0;

  typedef enum logic [1:0] {M_IDLE, M_SHIFT, M_DONE} m_state_t;
  m_state_t      m_st      = M_IDLE;
  logic [9:0]    m_sh      = '0;
  int            m_cnt     = 0;
  logic          m_started = 1'b0;
  logic          m_active  = 1'b0;
  logic          tx        = 1'b1;
  logic          m_req;

  assign m_req     = stall ? 1'b0 : txRequest;
  assign txStarted = stall ? fake_started : m_started;
  assign txActive  = stall ? fake_active  : m_active;

  logic [7:0]    sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .wrData    (wrData),
    .wrEnable  (wrEnable),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .txData    (txData),
    .txRequest (txRequest),
    .txStarted (txStarted),
    .txActive  (txActive)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wrData   = b;
    wrEnable = 1'b1;
    tick();
    wrEnable = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && txActive == 1'b0 && empty == 1'b1) done = 1'b1;
    end
    if (!done) timeout(name);
    tick();
  endtask

  // Transmitter: load on request, 10 shifts (start, 8 data LSB first,
  // stop), then hold until the request is low and drop txActive.
  always @(posedge clock) begin
    m_started <= 1'b0;
    case (m_st)
      M_IDLE: if (m_req === 1'b1) begin
        m_sh      <= {1'b1, txData, 1'b0};
        m_cnt     <= 10;
        m_st      <= M_SHIFT;
        m_started <= 1'b1;
        m_active  <= 1'b1;
      end
      M_SHIFT: begin
        tx    <= m_sh[0];
        m_sh  <= m_sh >> 1;
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_st <= M_DONE;
      end
      default: if (m_req !== 1'b1) begin
        m_st     <= M_IDLE;
        m_active <= 1'b0;
      end
    endcase
  end

  // Serial monitor: one sample per bit at the falling edge; each frame is
  // compared against the head of the expected-byte queue.
  logic       rx_busy    = 1'b0;
  int         rx_n       = 0;
  logic [9:0] rx_frame   = '0;
  logic [9:0] last_frame = '0;

  always @(negedge clock) begin
    if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy  = 1'b1;
        rx_frame = '0;
        rx_n     = 1;
      end
    end else begin
      rx_frame[rx_n] = tx;
      rx_n++;
      if (rx_n == 10) begin
        rx_busy    = 1'b0;
        rx_n       = 0;
        last_frame = rx_frame;
        check("stop_bit", 32'(rx_frame[9]), 32'd1);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL frame_byte: got 0x%0h, want no frame", rx_frame[8:1]);
        end else begin
          check("frame_byte", 32'(rx_frame[8:1]), 32'(sb.pop_front()));
        end
      end
    end
  end

  // Handshake watch: a new request never rises while the transmitter is
  // active, and txData never moves while the request is held.
  logic       req_q  = 1'b0;
  logic [7:0] data_q = '0;

  always @(negedge clock) begin
    if (txRequest === 1'b1 && req_q !== 1'b1) check("req_vs_active", 32'(txActive), 32'd0);
    if (txRequest === 1'b1 && req_q === 1'b1) check("txdata_stable", 32'(txData), 32'(data_q));
    req_q  = txRequest;
    data_q = txData;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;

    // Reset values
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    check("rst_empty",    32'(empty),     32'd1);
    check("rst_full",     32'(full),      32'd0);
    check("rst_count",    32'(count),     32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    check("rst_txreq",    32'(txRequest), 32'd0);
    check("rst_txdata",   32'(txData),    32'd0);
    reset = 1'b1;

    // Single byte through the transmitter
    sb.push_back(8'hA5);
    write_byte(8'hA5);
    @(negedge clock);
    check("wr_count",     32'(count),     32'd1);
    check("wr_empty",     32'(empty),     32'd0);
    check("req_not_yet",  32'(txRequest), 32'd0);
    @(negedge clock);
    check("req_after_wr", 32'(txRequest), 32'd1);
    check("req_data",     32'(txData),    32'h0A5);
    drain("single_drain", 200);
    check("a5_line_bits",  32'(last_frame), 32'h34A);
    check("single_count",  32'(count),      32'd0);
    check("single_txreq",  32'(txRequest),  32'd0);

    // Back-to-back burst
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(8'(i));
      write_byte(8'(i));
    end
    drain("burst_drain", 400);
    check("burst_overflow", 32'(overflow), 32'd0);
    check("burst_count",    32'(count),    32'd0);

    // Full / overflow with a stalled transmitter
    stall       = 1'b1;
    fake_active = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sb.push_back(8'(8'h10 + i));
      write_byte(8'(8'h10 + i));
    end
    @(negedge clock);
    check("fill_count",    32'(count),     32'd16);
    check("fill_full",     32'(full),      32'd1);
    check("fill_overflow", 32'(overflow),  32'd0);
    check("fill_txreq",    32'(txRequest), 32'd0);
    write_byte(8'hEE);
    @(negedge clock);
    check("drop_count",    32'(count),    32'd16);
    check("drop_overflow", 32'(overflow), 32'd1);
    #1 fake_active = 1'b0;
    @(negedge clock);
    check("stall_req",  32'(txRequest), 32'd1);
    check("stall_head", 32'(txData),    32'h10);
    #1;
    fake_started = 1'b1;
    fake_active  = 1'b1;
    wrData       = 8'h20;
    wrEnable     = 1'b1;
    tick();
    fake_started = 1'b0;
    wrEnable     = 1'b0;
    @(negedge clock);
    check("poppush_count", 32'(count),     32'd16);
    check("poppush_full",  32'(full),      32'd1);
    check("poppush_txreq", 32'(txRequest), 32'd0);
    void'(sb.pop_front());
    sb.push_back(8'h20);
    #1 stall = 1'b0;
    drain("full_drain", 1500);
    check("full_drain_count", 32'(count), 32'd0);

    // Pointer wrap: 40 sequential bytes, writing only when not full
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("rst2_overflow", 32'(overflow), 32'd0);
    check("rst2_count",    32'(count),    32'd0);
    for (int i = 0; i < 40; i++) begin
      guard = 0;
      while (full && guard < 1000) begin
        tick();
        guard++;
      end
      if (guard >= 1000) timeout("wrap_full_wait");
      sb.push_back(8'(i));
      write_byte(8'(i));
    end
    drain("wrap_drain", 3000);
    check("wrap_overflow", 32'(overflow), 32'd0);
    check("wrap_count",    32'(count),    32'd0);

    // Mid-frame reset with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      sb.push_back(8'(8'h30 + i));
      write_byte(8'(8'h30 + i));
    end
    guard = 0;
    while (!(rx_busy && rx_n == 4) && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) timeout("midframe_wait");
    check("queued_before_rst", 32'(count), 32'd3);
    while (sb.size() > 1) void'(sb.pop_back());
    reset = 1'b0;
    tick();
    @(negedge clock);
    check("midrst_count", 32'(count),     32'd0);
    check("midrst_txreq", 32'(txRequest), 32'd0);
    check("midrst_empty", 32'(empty),     32'd1);
    reset = 1'b1;
    sb.push_back(8'h5A);
    write_byte(8'h5A);
    @(negedge clock);
    check("held_while_active", 32'(txRequest), 32'd0);
    drain("midrst_drain", 400);
    check("midrst_final_count", 32'(count), 32'd0);
    check("scoreboard_empty",   32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
